// File: rtl/rf_commit_ctrl_pkg.sv
// Shared widths, state encoding and sizes for the ROB-head commit controller.
package rf_commit_ctrl_pkg;

    localparam int ROB_IDX_W = 4;
    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int REG_SIZE  = 32;

    typedef logic [ROB_IDX_W-1:0] rob_index_t;
    typedef logic [REG_IDX_W-1:0] reg_index_t;
    typedef logic [DATA_W-1:0]    data_t;
    typedef logic [ADDR_W-1:0]    addr_t;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_STORE_WAIT = 2'd1,
        ST_FLUSH_WALK = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/rf_commit_ctrl_walker.sv
// Register index walker used to clear every dependency tag after a flush.
module rf_tag_walker #(
    parameter int REG_NUM = 32
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       start,
    input  logic                       step,
    output logic [$clog2(REG_NUM)-1:0] idx,
    output logic                       last
);
    localparam int IDX_W = $clog2(REG_NUM);

    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;

    // x0 has no dependency tag, so a walk always begins at register 1.
    always_comb begin
        idx_d = idx_q;
        if (start) begin
            idx_d = IDX_W'(1);
        end else if (step) begin
            idx_d = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx  = idx_q;
    assign last = (idx_q == IDX_W'(REG_NUM - 1));

endmodule

// File: rtl/rf_commit_ctrl.sv
// In-order ROB-head retirement: RF commit, store handshake with the LSB, and
// mispredict flush followed by a walk that clears every RF dependency tag.
module rf_commit_ctrl
    import rf_commit_ctrl_pkg::*;
#(
    parameter int ROB_IDX_W = 4,
    parameter int REG_NUM   = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 rob_head_valid,
    input  logic                 rob_head_ready,
    input  logic [ROB_IDX_W-1:0] rob_head_index,
    input  logic [4:0]           rob_head_rd,
    input  logic [31:0]          rob_head_val,
    input  logic                 rob_head_is_store,
    input  logic                 rob_head_mispredict,
    input  logic [31:0]          rob_head_target_pc,
    output logic                 ctrl_to_rob_pop,
    input  logic                 lsb_store_done,
    output logic                 ctrl_to_lsb_store_go,
    output logic                 ctrl_to_reg_commit,
    output logic [ROB_IDX_W-1:0] ctrl_to_reg_rob_index,
    output logic [4:0]           ctrl_to_reg_index,
    output logic [31:0]          ctrl_to_reg_val,
    output logic                 ctrl_to_reg_tag_clr,
    output logic [4:0]           ctrl_to_reg_tag_clr_index,
    output logic                 ctrl_clr_out,
    output logic                 ctrl_pc_redirect_valid,
    output logic [31:0]          ctrl_pc_redirect_target,
    output logic                 ctrl_issue_stall,
    output logic [31:0]          ctrl_commit_count
);
    ctrl_state_e          state_q, state_d;
    logic [31:0]          count_q, count_d;
    logic                 commit_q, commit_d;
    logic [ROB_IDX_W-1:0] rob_idx_q, rob_idx_d;
    logic [4:0]           reg_idx_q, reg_idx_d;
    data_t                val_q, val_d;
    logic                 go_q, go_d;
    logic                 clr_q, clr_d;
    logic                 redir_q, redir_d;
    addr_t                target_q, target_d;
    logic                 tag_clr_q, tag_clr_d;
    logic [4:0]           tag_idx_q, tag_idx_d;
    logic                 stall_q, stall_d;
    logic                 pop;
    logic                 walk_start;
    logic                 walk_step;
    logic [4:0]           walk_idx;
    logic                 walk_last;

    rf_tag_walker #(.REG_NUM(REG_NUM)) u_walker (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .start  (walk_start),
        .step   (walk_step),
        .idx    (walk_idx),
        .last   (walk_last)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        commit_d   = 1'b0;
        rob_idx_d  = rob_idx_q;
        reg_idx_d  = reg_idx_q;
        val_d      = val_q;
        go_d       = 1'b0;
        clr_d      = 1'b0;
        redir_d    = 1'b0;
        target_d   = target_q;
        tag_clr_d  = 1'b0;
        tag_idx_d  = tag_idx_q;
        pop        = 1'b0;
        walk_start = 1'b0;
        walk_step  = 1'b0;

        if (rdy_in) begin
            case (state_q)
                ST_RUN: begin
                    if (rob_head_valid && rob_head_ready) begin
                        if (rob_head_is_store && !rob_head_mispredict) begin
                            go_d    = 1'b1;
                            state_d = ST_STORE_WAIT;
                        end else begin
                            // Mispredicted heads still retire their own result.
                            pop       = 1'b1;
                            commit_d  = (rob_head_rd != 5'd0);
                            rob_idx_d = rob_head_index;
                            reg_idx_d = rob_head_rd;
                            val_d     = rob_head_val;
                            count_d   = count_q + 32'd1;
                            if (rob_head_mispredict) begin
                                clr_d      = 1'b1;
                                redir_d    = 1'b1;
                                target_d   = rob_head_target_pc;
                                state_d    = ST_FLUSH_WALK;
                                walk_start = 1'b1;
                            end
                        end
                    end
                end
                ST_STORE_WAIT: begin
                    if (lsb_store_done) begin
                        pop     = 1'b1;
                        count_d = count_q + 32'd1;
                        state_d = ST_RUN;
                    end
                end
                ST_FLUSH_WALK: begin
                    tag_clr_d = 1'b1;
                    tag_idx_d = walk_idx;
                    walk_step = 1'b1;
                    if (walk_last) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end

        // Stall covers the whole walk, including the final tag-clear strobe.
        stall_d = (state_d == ST_FLUSH_WALK) || tag_clr_d;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q   <= ST_RUN;
            count_q   <= '0;
            commit_q  <= 1'b0;
            rob_idx_q <= '0;
            reg_idx_q <= '0;
            val_q     <= '0;
            go_q      <= 1'b0;
            clr_q     <= 1'b0;
            redir_q   <= 1'b0;
            target_q  <= '0;
            tag_clr_q <= 1'b0;
            tag_idx_q <= '0;
            stall_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            commit_q  <= commit_d;
            rob_idx_q <= rob_idx_d;
            reg_idx_q <= reg_idx_d;
            val_q     <= val_d;
            go_q      <= go_d;
            clr_q     <= clr_d;
            redir_q   <= redir_d;
            target_q  <= target_d;
            tag_clr_q <= tag_clr_d;
            tag_idx_q <= tag_idx_d;
            stall_q   <= stall_d;
        end
    end

    assign ctrl_to_rob_pop           = pop && rst_in;
    assign ctrl_to_lsb_store_go      = go_q;
    assign ctrl_to_reg_commit        = commit_q;
    assign ctrl_to_reg_rob_index     = rob_idx_q;
    assign ctrl_to_reg_index         = reg_idx_q;
    assign ctrl_to_reg_val           = val_q;
    assign ctrl_to_reg_tag_clr       = tag_clr_q;
    assign ctrl_to_reg_tag_clr_index = tag_idx_q;
    assign ctrl_clr_out              = clr_q;
    assign ctrl_pc_redirect_valid    = redir_q;
    assign ctrl_pc_redirect_target   = target_q;
    assign ctrl_issue_stall          = stall_q;
    assign ctrl_commit_count         = count_q;

endmodule
